// File: rtl/lz_pkg.sv
// rtl/lz_pkg.sv - shared types, widths and stage sizing for the leading/trailing-zero normalizer
package lz_pkg;

    localparam int LZ_WIDTH = 32;
    localparam int LZ_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } lz_state_e;

    // Binary-search stage size: 16, 8, 4, 2, 1 for steps 0..4
    function automatic logic [5:0] stage_k(input logic [2:0] step);
        return 6'(5'd16 >> step);
    endfunction

endpackage

// File: rtl/bit_reverse32.sv
// rtl/bit_reverse32.sv - combinational 32-bit reversal with bypass when disabled
module bit_reverse32 (
    input  logic        en,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [31:0] rev;

    always_comb begin
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            rev[i] = data[31-i];
        end
        result = en ? rev : data;
    end

endmodule

// File: rtl/lz_normalizer.sv
// rtl/lz_normalizer.sv - multi-cycle clz/ctz unit returning the zero count and the normalized operand
module lz_normalizer
    import lz_pkg::*;
#(
    parameter int WIDTH = LZ_WIDTH,
    parameter int CNT_W = LZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] norm,
    output logic             busy
);

    lz_state_e        state;
    lz_state_e        state_nxt;
    logic [2:0]       step;
    logic [31:0]      working;
    logic [31:0]      working_nxt;
    logic [5:0]       cnt_acc;
    logic [5:0]       cnt_nxt;
    logic             mode_q;
    logic             zero_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] norm_q;
    logic [31:0]      in_rev;
    logic [31:0]      out_rev;
    logic [5:0]       k;
    logic [31:0]      top_mask;
    logic             top_zero;

    // ctz is handled as clz on the reversed operand, then reversed back
    bit_reverse32 u_in_rev (
        .en     (mode),
        .data   (data_in),
        .result (in_rev)
    );

    bit_reverse32 u_out_rev (
        .en     (mode_q),
        .data   (working_nxt),
        .result (out_rev)
    );

    always_comb begin
        k           = stage_k(step);
        top_mask    = ~(32'hFFFF_FFFF >> k);
        top_zero    = (working & top_mask) == 32'd0;
        working_nxt = top_zero ? (working << k) : working;
        cnt_nxt     = top_zero ? (cnt_acc + k) : cnt_acc;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = SHIFT;
                SHIFT:   if (step == 3'd4) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step    <= '0;
            working <= '0;
            cnt_acc <= '0;
            mode_q  <= 1'b0;
            zero_q  <= 1'b0;
            count_q <= '0;
            norm_q  <= '0;
        end else if (flush) begin
            step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        working <= in_rev;
                        mode_q  <= mode;
                        zero_q  <= (data_in == '0);
                        cnt_acc <= '0;
                        step    <= '0;
                    end
                end
                SHIFT: begin
                    working <= working_nxt;
                    cnt_acc <= cnt_nxt;
                    if (step == 3'd4) begin
                        step    <= '0;
                        count_q <= zero_q ? CNT_W'(32) : CNT_W'(cnt_nxt);
                        norm_q  <= zero_q ? '0 : WIDTH'(out_rev);
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign count     = count_q;
    assign norm      = norm_q;

endmodule
